// File: rtl/ether_rx_if.sv
// RMII receive bundle: raw crsdv/rxd in, payload dibit stream out.
// master drives the wire side, slave is the receiver front end.
interface ether_rx_if;
  logic       crsdv;
  logic [1:0] rxd;
  logic       axiov;
  logic [1:0] axiod;
  logic       frame_start;
  logic       frame_end;
  logic       frame_err;

  modport master (
    output crsdv, rxd,
    input  axiov, axiod,
    input  frame_start, frame_end, frame_err
  );

  modport slave (
    input  crsdv, rxd,
    output axiov, axiod,
    output frame_start, frame_end, frame_err
  );
endinterface

// File: rtl/ether_rx.sv
// RMII rx front end: finds preamble+SFD, forwards payload dibits.
// Ports: clk, rst (async, active-low), rx (crsdv/rxd in, axiov/axiod/frame_* out).
module ether_rx #(
  parameter int MIN_PRE    = 28,
  parameter int MAX_DIBITS = 6072
) (
  input logic       clk,
  input logic       rst,
  ether_rx_if.slave rx
);

  localparam int DW = $clog2(MAX_DIBITS + 1);
  localparam logic [5:0]    MIN_W = 6'(MIN_PRE);
  localparam logic [DW-1:0] MAX_W = DW'(MAX_DIBITS);

  typedef enum logic [2:0] {
    IDLE, PRE, DATA, TRUNC, DROP
  } state_t;

  state_t        state_q, state_d;
  logic [5:0]    pre_q, pre_d;
  logic [DW-1:0] dib_q, dib_d;
  logic          err_q, err_d;
  logic          v_q, v_d;
  logic [1:0]    d_q, d_d;
  logic          s_q, s_d;
  logic          e_q, e_d;
  logic          fe_q, fe_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
      dib_q   <= '0;
      err_q   <= 1'b0;
      v_q     <= 1'b0;
      d_q     <= 2'b00;
      s_q     <= 1'b0;
      e_q     <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      dib_q   <= dib_d;
      err_q   <= err_d;
      v_q     <= v_d;
      d_q     <= d_d;
      s_q     <= s_d;
      e_q     <= e_d;
      fe_q    <= fe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    dib_d   = dib_q;
    err_d   = err_q;
    v_d     = 1'b0;
    d_d     = d_q;
    s_d     = 1'b0;
    e_d     = 1'b0;
    fe_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx.crsdv) begin
          if (rx.rxd == 2'b01) begin
            state_d = PRE;
            pre_d   = 6'd1;
          end else begin
            state_d = DROP;
          end
        end
      end
      PRE: begin
        if (!rx.crsdv) begin
          state_d = IDLE;
        end else begin
          unique case (rx.rxd)
            2'b01: begin
              if (pre_q != 6'd63)
                pre_d = pre_q + 6'd1;
            end
            2'b11: begin
              if (pre_q >= MIN_W) begin
                state_d = DATA;
                dib_d   = '0;
                err_d   = 1'b0;
              end else begin
                fe_d    = 1'b1;
                state_d = DROP;
              end
            end
            default: begin
              fe_d    = 1'b1;
              state_d = DROP;
            end
          endcase
        end
      end
      DATA: begin
        if (rx.crsdv) begin
          // Overflow is detected on the dibit past the limit, so a
          // frame of exactly MAX_DIBITS still ends cleanly.
          if (dib_q == MAX_W) begin
            err_d   = 1'b1;
            state_d = TRUNC;
          end else begin
            v_d   = 1'b1;
            d_d   = rx.rxd;
            s_d   = (dib_q == '0);
            dib_d = dib_q + 1'b1;
          end
        end else begin
          e_d     = 1'b1;
          fe_d    = (dib_q[1:0] != 2'b00) ||
                    (dib_q == '0) || err_q;
          state_d = IDLE;
        end
      end
      TRUNC: begin
        if (!rx.crsdv) begin
          e_d     = 1'b1;
          fe_d    = 1'b1;
          state_d = IDLE;
        end
      end
      DROP: begin
        if (!rx.crsdv)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx.axiov       = v_q;
  assign rx.axiod       = d_q;
  assign rx.frame_start = s_q;
  assign rx.frame_end   = e_q;
  assign rx.frame_err   = fe_q;

endmodule

// File: tb/tb_ether_rx.sv
// Scoreboard bench for ether_rx: default DUT plus a MAX_DIBITS=8 DUT.
// Expected output events are queued by stimulus, popped by monitors.
module tb_ether_rx;

  typedef struct packed {
    logic       s;
    logic       e;
    logic       er;
    logic       v;
    logic [1:0] d;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       crsdv = 1'b0;
  logic [1:0] rxd = 2'b00;
  logic       sel = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  exp_t qa[$];
  exp_t qb[$];

  ether_rx_if ifa ();
  ether_rx_if ifb ();

  assign ifa.crsdv = sel ? 1'b0 : crsdv;
  assign ifa.rxd   = sel ? 2'b00 : rxd;
  assign ifb.crsdv = sel ? crsdv : 1'b0;
  assign ifb.rxd   = sel ? rxd : 2'b00;

  ether_rx dut_a (
    .clk (clk),
    .rst (rst),
    .rx  (ifa.slave)
  );

  ether_rx #(.MAX_DIBITS(8)) dut_b (
    .clk (clk),
    .rst (rst),
    .rx  (ifb.slave)
  );

  always #5 clk = ~clk;

  function automatic void push(input exp_t x);
    if (sel) qb.push_back(x);
    else     qa.push_back(x);
  endfunction

  task automatic chk(input string nm, input logic [7:0] got,
                     input logic [7:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic pop_cmp(input int id, input exp_t got);
    exp_t x;
    int   sz;
    sz = (id == 0) ? qa.size() : qb.size();
    n_chk++;
    if (sz == 0) begin
      n_fail++;
      $display("FAIL unexpected_out dut%0d t=%0t: got %b want none",
               id, $time, got);
    end else begin
      x = (id == 0) ? qa.pop_front() : qb.pop_front();
      if (!x.v) begin
        x.d   = 2'b00;
        got.d = 2'b00;
      end
      if (got !== x) begin
        n_fail++;
        $display("FAIL event dut%0d t=%0t: got %b want %b",
                 id, $time, got, x);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst && (ifa.axiov || ifa.frame_start ||
                ifa.frame_end || ifa.frame_err))
      pop_cmp(0, {ifa.frame_start, ifa.frame_end,
                  ifa.frame_err, ifa.axiov, ifa.axiod});
  end

  always @(negedge clk) begin
    if (rst && (ifb.axiov || ifb.frame_start ||
                ifb.frame_end || ifb.frame_err))
      pop_cmp(1, {ifb.frame_start, ifb.frame_end,
                  ifb.frame_err, ifb.axiov, ifb.axiod});
  end

  task automatic drive(input logic c, input logic [1:0] r);
    @(posedge clk);
    #1;
    crsdv = c;
    rxd   = r;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 2'b00);
  endtask

  task automatic pre(input int n);
    repeat (n) drive(1'b1, 2'b01);
  endtask

  task automatic sfd();
    drive(1'b1, 2'b11);
  endtask

  // Sends n dibits of w MSB first; only the first npush are expected.
  task automatic send(input logic [31:0] w, input int n,
                      input int npush);
    logic [31:0] t;
    logic [1:0]  dib;
    t = w;
    for (int i = 0; i < n; i++) begin
      dib = t[31:30];
      t   = t << 2;
      drive(1'b1, dib);
      if (i < npush)
        push('{s: (i == 0), e: 1'b0, er: 1'b0, v: 1'b1, d: dib});
    end
  endtask

  task automatic end_ev(input logic err);
    push('{s: 1'b0, e: 1'b1, er: err, v: 1'b0, d: 2'b00});
  endtask

  task automatic clean(input logic [31:0] w);
    pre(28);
    sfd();
    send(w, 16, 16);
    end_ev(1'b0);
    idle(3);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_axiov_a", {7'd0, ifa.axiov}, 8'd0);
    chk("rst_axiod_a", {6'd0, ifa.axiod}, 8'd0);
    chk("rst_flags_a", {5'd0, ifa.frame_start,
        ifa.frame_end, ifa.frame_err}, 8'd0);
    chk("rst_axiov_b", {7'd0, ifb.axiov}, 8'd0);
    chk("rst_flags_b", {5'd0, ifb.frame_start,
        ifb.frame_end, ifb.frame_err}, 8'd0);
    rst = 1'b1;
    idle(2);

    // clean frame: 00,01,00,10,00,11,01,00,01,01,01,10,01,11,10,00
    clean(32'h1234_5678);

    // runt preamble: error right after SFD, rest of frame dropped
    pre(10);
    sfd();
    push('{s: 1'b0, e: 1'b0, er: 1'b1, v: 1'b0, d: 2'b00});
    send(32'hFFFF_FFFF, 8, 0);
    idle(3);
    clean(32'hA5C3_0F96);

    // bad preamble dibit, then carrier held a while
    pre(20);
    drive(1'b1, 2'b10);
    push('{s: 1'b0, e: 1'b0, er: 1'b1, v: 1'b0, d: 2'b00});
    drive(1'b1, 2'b11);
    drive(1'b1, 2'b01);
    drive(1'b1, 2'b00);
    idle(3);

    // misaligned end: 6 dibits
    pre(28);
    sfd();
    send(32'hDEAD_BEEF, 6, 6);
    end_ev(1'b1);
    idle(3);

    // zero-length payload: end+err, no start
    pre(30);
    sfd();
    end_ev(1'b1);
    idle(3);

    // preamble dropped carrier: silent return to IDLE
    pre(15);
    idle(2);
    clean(32'h0F0F_3C3C);

    // over-length on the MAX_DIBITS=8 instance
    sel = 1'b1;
    idle(2);
    pre(28);
    sfd();
    send(32'hCAFE_F00D, 12, 8);
    end_ev(1'b1);
    idle(3);
    // exactly MAX dibits is a good frame
    pre(28);
    sfd();
    send(32'h8421_1248, 8, 8);
    end_ev(1'b0);
    idle(3);
    sel = 1'b0;
    idle(2);

    // async reset mid-DATA after 5 payload dibits
    pre(28);
    sfd();
    send(32'h9876_5432, 5, 5);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst   = 1'b0;
    crsdv = 1'b0;
    rxd   = 2'b00;
    #1;
    chk("mid_rst_axiov", {7'd0, ifa.axiov}, 8'd0);
    chk("mid_rst_end", {7'd0, ifa.frame_end}, 8'd0);
    chk("mid_rst_err", {7'd0, ifa.frame_err}, 8'd0);
    #3;
    rst = 1'b1;
    idle(2);
    clean(32'hF00D_1234);
    idle(4);

    chk("qa_drained", 8'(qa.size()), 8'd0);
    chk("qb_drained", 8'(qb.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
